// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one external memory bus between the instruction-fetch
//            port and the execute stage's load/store port. Each access is
//            sequenced with a valid/ready handshake. hlt stalls the pipeline
//            while a data request is outstanding.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   TIMEOUT    : wait cycles before an access is aborted (1..65535). It is
//                used only when MEM_ARB_TIMEOUT_EN is defined.
// Build option
//   MEM_ARB_TIMEOUT_EN : enables the bus-timeout watchdog and the fault
//                        pulse. When undefined, accesses wait indefinitely
//                        and fault is tied low.
// Ports
//   clk, rst                    : clock (rising edge), async active-low reset
//   i_valid/i_addr              : fetch request
//   i_ready/i_rdata             : fetch completion pulse and fetched word
//   d_valid/d_addr/d_wdata/d_wstrb : load/store request (wstrb==0 -> load)
//   d_ready/d_rdata             : data completion pulse and load data
//   hlt                         : pipeline stall = d_valid & ~d_ready
//   fault                       : one-cycle bus timeout pulse
//   mem_valid/addr/wdata/wstrb  : registered bus request
//   mem_ready/mem_rdata         : bus completion and read data
// ============================================================================
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    output logic [31:0] i_rdata,
    input  logic        d_valid,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        hlt,
    output logic        fault,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_IFETCH = 2'd1,
        ST_DATA   = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_last;        // last grant: 0 = instruction, 1 = data
    logic        r_mem_valid;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_wstrb;

    logic        w_busy;
    logic        w_timeout;
    logic        w_finish;
    logic        w_grant_d;

    // Reject out-of-range configurations at elaboration time.
    if ((TIMEOUT < 1) || (TIMEOUT > 65535)) begin : g_bad_timeout
        $error("mem_arbiter: TIMEOUT must be in 1..65535");
    end

    assign w_busy = (r_state != ST_IDLE);

`ifdef MEM_ARB_TIMEOUT_EN
    // The count held in the register is the number of wait cycles already
    // elapsed, so the abort fires in the wait cycle that brings the total
    // to TIMEOUT.
    localparam logic [15:0] c_timeout_last = 16'(TIMEOUT - 1);

    logic [15:0] r_wait_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait_cnt <= 16'd0;
        end else if (!w_busy) begin
            r_wait_cnt <= 16'd0;
        end else if (!mem_ready) begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
        end
    end

    // A mem_ready in the abort cycle takes priority over the timeout.
    assign w_timeout = w_busy & ~mem_ready & (r_wait_cnt == c_timeout_last);
`else
    assign w_timeout = 1'b0;
`endif

    // mem_ready is only meaningful while an access is on the bus.
    assign w_finish = w_busy & (mem_ready | w_timeout);

    // Data wins when it is the only requester, or on a tie when the
    // instruction port was served last.
    assign w_grant_d = d_valid & (~i_valid | ~r_last);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_last      <= 1'b0;
            r_mem_valid <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_mem_wstrb <= 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_d) begin
                        r_state     <= ST_DATA;
                        r_last      <= 1'b1;
                        r_mem_valid <= 1'b1;
                        r_mem_addr  <= d_addr;
                        r_mem_wdata <= d_wdata;
                        r_mem_wstrb <= d_wstrb;
                    end else if (i_valid) begin
                        r_state     <= ST_IFETCH;
                        r_last      <= 1'b0;
                        r_mem_valid <= 1'b1;
                        r_mem_addr  <= i_addr;
                        r_mem_wdata <= 32'd0;
                        r_mem_wstrb <= 4'd0;
                    end
                end
                ST_IFETCH, ST_DATA: begin
                    if (w_finish) begin
                        r_state     <= ST_IDLE;
                        r_mem_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_mem_valid <= 1'b0;
                end
            endcase
        end
    end

    // Completion is reported in the same cycle the bus (or watchdog)
    // finishes; rdata is forced to zero unless the bus actually answered.
    assign i_ready   = (r_state == ST_IFETCH) & w_finish;
    assign d_ready   = (r_state == ST_DATA)   & w_finish;
    assign i_rdata   = ((r_state == ST_IFETCH) & mem_ready) ? mem_rdata : 32'd0;
    assign d_rdata   = ((r_state == ST_DATA)   & mem_ready) ? mem_rdata : 32'd0;
    assign hlt       = d_valid & ~d_ready;
    assign fault     = w_timeout;

    assign mem_valid = r_mem_valid;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wstrb = r_mem_wstrb;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed self-checking bench for mem_arbiter. Inputs change on
//            the falling clock edge; outputs are sampled 1 ns later.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_valid = 1'b0;
    logic [31:0] i_addr = 32'd0;
    logic        i_ready;
    logic [31:0] i_rdata;
    logic        d_valid = 1'b0;
    logic [31:0] d_addr = 32'd0;
    logic [31:0] d_wdata = 32'd0;
    logic [3:0]  d_wstrb = 4'd0;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        hlt;
    logic        fault;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
`ifdef MEM_ARB_TIMEOUT_EN
        .TIMEOUT(4)
`else
        .TIMEOUT(255)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (i_valid),
        .i_addr    (i_addr),
        .i_ready   (i_ready),
        .i_rdata   (i_rdata),
        .d_valid   (d_valid),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wstrb   (d_wstrb),
        .d_ready   (d_ready),
        .d_rdata   (d_rdata),
        .hlt       (hlt),
        .fault     (fault),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge (input-drive point).
    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        // ---------------- reset with a pending fetch ----------------
        rst = 1'b0; i_valid = 1'b1; i_addr = 32'h0000_0010;
        step(); step();
        #1;
        chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
        chk("rst_i_ready", {31'd0, i_ready}, 32'd0);
        chk("rst_d_ready", {31'd0, d_ready}, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_hlt", {31'd0, hlt}, 32'd0);

        // ---------------- fetch with two wait cycles ----------------
        step(); rst = 1'b1;
        step(); #1;                                  // wait cycle 1
        chk("if_mem_valid", {31'd0, mem_valid}, 32'd1);
        chk("if_mem_addr", mem_addr, 32'h0000_0010);
        chk("if_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
        chk("if_wait1_ready", {31'd0, i_ready}, 32'd0);
        step(); #1;                                  // wait cycle 2
        chk("if_wait2_ready", {31'd0, i_ready}, 32'd0);
        step(); mem_ready = 1'b1; mem_rdata = 32'h0050_0093; #1;
        chk("if_i_ready", {31'd0, i_ready}, 32'd1);
        chk("if_i_rdata", i_rdata, 32'h0050_0093);
        chk("if_d_ready", {31'd0, d_ready}, 32'd0);
        chk("if_d_rdata", d_rdata, 32'd0);
        step(); i_valid = 1'b0; mem_ready = 1'b0; mem_rdata = 32'd0; #1;
        chk("if_idle_valid", {31'd0, mem_valid}, 32'd0);
        chk("if_idle_ready", {31'd0, i_ready}, 32'd0);

        // ---------------- store, zero-wait bus ----------------
        step();
        d_valid = 1'b1; d_addr = 32'h0000_0100; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'hF;
        mem_ready = 1'b1; #1;                        // ignored while idle
        chk("st_hlt_req", {31'd0, hlt}, 32'd1);
        chk("st_idle_dready", {31'd0, d_ready}, 32'd0);
        step(); #1;
        chk("st_mem_valid", {31'd0, mem_valid}, 32'd1);
        chk("st_mem_addr", mem_addr, 32'h0000_0100);
        chk("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("st_mem_wstrb", {28'd0, mem_wstrb}, 32'hF);
        chk("st_d_ready", {31'd0, d_ready}, 32'd1);
        chk("st_hlt_done", {31'd0, hlt}, 32'd0);
        step(); d_valid = 1'b0; mem_ready = 1'b0; #1;
        chk("st_after_hlt", {31'd0, hlt}, 32'd0);
        chk("st_after_valid", {31'd0, mem_valid}, 32'd0);

        // ---------------- round-robin after reset ----------------
        step(); rst = 1'b0;
        i_valid = 1'b1; i_addr = 32'h0000_0200;
        d_valid = 1'b1; d_addr = 32'h0000_0300; d_wdata = 32'h0; d_wstrb = 4'h0;
        mem_ready = 1'b1;
        step(); rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(); mem_rdata = 32'hA5A5_0000 + k; #1;
            if ((k % 2) == 0) begin
                chk($sformatf("rr%0d_addr", k), mem_addr, 32'h0000_0300);
                chk($sformatf("rr%0d_d_ready", k), {31'd0, d_ready}, 32'd1);
                chk($sformatf("rr%0d_i_ready", k), {31'd0, i_ready}, 32'd0);
                chk($sformatf("rr%0d_d_rdata", k), d_rdata, 32'hA5A5_0000 + k);
                chk($sformatf("rr%0d_i_rdata", k), i_rdata, 32'd0);
            end else begin
                chk($sformatf("rr%0d_addr", k), mem_addr, 32'h0000_0200);
                chk($sformatf("rr%0d_i_ready", k), {31'd0, i_ready}, 32'd1);
                chk($sformatf("rr%0d_d_ready", k), {31'd0, d_ready}, 32'd0);
                chk($sformatf("rr%0d_i_rdata", k), i_rdata, 32'hA5A5_0000 + k);
                chk($sformatf("rr%0d_hlt", k), {31'd0, hlt}, 32'd1);
            end
            step(); #1;
            chk($sformatf("rr%0d_gap", k), {31'd0, mem_valid}, 32'd0);
        end

        // ---------------- reset in the middle of a data access ----------------
        // The idle cycle of the last loop iteration already granted data
        // (last = instruction); drop the fetch and hold the bus off.
        i_valid = 1'b0; mem_ready = 1'b0;
        step(); #1;
        chk("mr_mem_valid", {31'd0, mem_valid}, 32'd1);
        chk("mr_mem_addr", mem_addr, 32'h0000_0300);
        #2; rst = 1'b0; mem_ready = 1'b1; #1;
        chk("mr_valid_drop", {31'd0, mem_valid}, 32'd0);
        chk("mr_no_dready", {31'd0, d_ready}, 32'd0);
        chk("mr_addr_clr", mem_addr, 32'd0);
        chk("mr_hlt", {31'd0, hlt}, 32'd1);
        step(); rst = 1'b1;
        step(); #1;
        chk("mr_rearb_valid", {31'd0, mem_valid}, 32'd1);
        chk("mr_rearb_ready", {31'd0, d_ready}, 32'd1);
        step(); d_valid = 1'b0; mem_ready = 1'b0; mem_rdata = 32'h1234_5678;

        // ---------------- bus never answers ----------------
        step(); d_valid = 1'b1; d_addr = 32'h0000_0400; d_wstrb = 4'h0;
`ifdef MEM_ARB_TIMEOUT_EN
        for (int w = 1; w <= 3; w++) begin
            step(); #1;
            chk($sformatf("to_wait%0d_ready", w), {31'd0, d_ready}, 32'd0);
            chk($sformatf("to_wait%0d_fault", w), {31'd0, fault}, 32'd0);
        end
        step(); #1;
        chk("to_abort_ready", {31'd0, d_ready}, 32'd1);
        chk("to_abort_rdata", d_rdata, 32'd0);
        chk("to_abort_fault", {31'd0, fault}, 32'd1);
        step(); d_valid = 1'b0; #1;
        chk("to_after_valid", {31'd0, mem_valid}, 32'd0);
        chk("to_after_fault", {31'd0, fault}, 32'd0);
`else
        for (int w = 1; w <= 6; w++) begin
            step(); #1;
            chk($sformatf("hang%0d_ready", w), {31'd0, d_ready}, 32'd0);
            chk($sformatf("hang%0d_fault", w), {31'd0, fault}, 32'd0);
        end
        chk("hang_valid", {31'd0, mem_valid}, 32'd1);
        chk("hang_hlt", {31'd0, hlt}, 32'd1);
        step(); rst = 1'b0; d_valid = 1'b0;
        step(); rst = 1'b1;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
